// File: rtl/spi_apb_bridge_if.sv
// APB bus bundle between spi_apb_bridge (master) and the register file (slave).
interface spi_apb_bridge_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  // Handshake: a transfer is one setup cycle (psel=1, penable=0) followed by
  // access cycles (psel=1, penable=1) until the first cycle with pready=1, which
  // completes it and carries prdata/pslverr. paddr/pwrite/pwdata hold steady
  // from setup through that completing cycle; psel drops the cycle after.
  modport master (output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
                  input  pready, prdata, pslverr);
  modport slave  (input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
                  output pready, prdata, pslverr);
endinterface

// File: rtl/spi_apb_bridge.sv
// SPI mode-0 slave to APB master bridge. Each SPI frame becomes one APB
// transfer. SPI pins are oversampled in the pclk domain.
module spi_apb_bridge #(
  parameter int ADDR_WIDTH  = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             busy,
  output logic             err,
  output logic [2:0]       dbg_spi_state,
  output logic [1:0]       dbg_apb_state,
  spi_apb_bridge_if.master apb
);

  localparam int CW = $clog2(DATA_WIDTH + 17);
  localparam logic [CW-1:0] C_CMD_LAST = CW'(7);
  localparam logic [CW-1:0] C_WR_LAST  = CW'(7 + DATA_WIDTH);
  localparam logic [CW-1:0] C_RD_LOAD  = CW'(16);
  localparam logic [CW-1:0] C_RD_LAST  = CW'(15 + DATA_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDUMMY, S_RDATA, S_DONE} spi_state_t;
  typedef enum logic [1:0] {A_IDLE, A_SETUP, A_ACCESS} apb_state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d;
  logic                   w_sclk_s, w_cs_s, w_mosi_s, w_rise, w_fall;

  spi_state_t             r_spi_state;
  logic [CW-1:0]          r_bit_cnt;
  logic [6:0]             r_cmd;
  logic [DATA_WIDTH-2:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  r_tx;
  logic                   r_rd_seq;

  apb_state_t             r_apb_state;
  logic                   r_psel, r_penable, r_pwrite, r_cur_seq;
  logic [ADDR_WIDTH-1:0]  r_paddr;
  logic [DATA_WIDTH-1:0]  r_pwdata, r_rdata;
  logic                   r_rd_valid;
  logic                   r_pend_valid, r_pend_write, r_pend_seq;
  logic [ADDR_WIDTH-1:0]  r_pend_addr;
  logic [DATA_WIDTH-1:0]  r_pend_data;
  logic                   r_err;

  logic [7:0]             w_cmd_next;
  logic [DATA_WIDTH-1:0]  w_wdata_next;
  logic                   w_launch_rd, w_launch_wr, w_launch, w_take_launch, w_issue_pend;
  logic [ADDR_WIDTH-1:0]  w_l_addr;
  logic [DATA_WIDTH-1:0]  w_l_data;
  logic                   w_rd_return, w_late, w_done;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise   = w_sclk_s & ~r_sclk_d;
  assign w_fall   = ~w_sclk_s & r_sclk_d;

  // Synchronise the SPI pins and keep the previous sclk for edge detection.
  // cs_n resets high so reset never looks like the start of a frame.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= w_sclk_s;
    end
  end

  // Launch requests are combinational so the APB setup lands in the very next cycle.
  assign w_cmd_next   = {r_cmd, w_mosi_s};
  assign w_wdata_next = {r_wdata, w_mosi_s};
  assign w_launch_rd  = !w_cs_s && (r_spi_state == S_CMD) && w_rise &&
                        (r_bit_cnt == C_CMD_LAST) && !w_cmd_next[7];
  assign w_launch_wr  = !w_cs_s && (r_spi_state == S_WDATA) && w_rise &&
                        (r_bit_cnt == C_WR_LAST);
  assign w_launch     = w_launch_rd | w_launch_wr;
  assign w_l_addr     = w_launch_rd ? w_cmd_next[ADDR_WIDTH-1:0] : r_cmd[ADDR_WIDTH-1:0];
  assign w_l_data     = w_launch_wr ? w_wdata_next : '0;
  assign w_rd_return  = !w_cs_s && (r_spi_state == S_RDUMMY) && w_fall &&
                        (r_bit_cnt == C_RD_LOAD);
  assign w_late       = w_rd_return && !r_rd_valid;

  // SPI frame FSM: shifts in command/write data, shifts out read data; r_tx MSB is miso.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_spi_state <= S_IDLE;
      r_bit_cnt   <= '0;
      r_cmd       <= '0;
      r_wdata     <= '0;
      r_tx        <= '0;
      r_rd_seq    <= 1'b0;
    end else if (w_cs_s) begin
      r_spi_state <= S_IDLE;
      r_bit_cnt   <= '0;
      r_tx        <= '0;
    end else begin
      case (r_spi_state)
        S_IDLE: begin
          r_spi_state <= S_CMD;
          r_bit_cnt   <= '0;
          r_tx        <= '0;
        end
        S_CMD: if (w_rise) begin
          r_cmd     <= w_cmd_next[6:0];
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == C_CMD_LAST) begin
            r_spi_state <= w_cmd_next[7] ? S_WDATA : S_RDUMMY;
            if (!w_cmd_next[7]) r_rd_seq <= ~r_rd_seq;
          end
        end
        S_WDATA: if (w_rise) begin
          r_wdata   <= w_wdata_next[DATA_WIDTH-2:0];
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == C_WR_LAST) r_spi_state <= S_DONE;
        end
        S_RDUMMY: begin
          if (w_rise) r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_rd_return) begin
            r_tx        <= r_rd_valid ? r_rdata : '0;
            r_spi_state <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (w_rise) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == C_RD_LAST) begin
              r_spi_state <= S_DONE;
              r_tx        <= '0;
            end
          end else if (w_fall) begin
            r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
          end
        end
        S_DONE:  r_tx <= '0;
        default: r_spi_state <= S_IDLE;
      endcase
    end
  end

  // A launch arriving while the APB side is busy parks in the one-deep pending slot.
  assign w_take_launch = (r_apb_state == A_IDLE) && !r_pend_valid && w_launch;
  assign w_issue_pend  = (r_apb_state == A_IDLE) && r_pend_valid;
  assign w_done        = (r_apb_state == A_ACCESS) && apb.pready;

  // APB master FSM; a read result is kept only if it belongs to the latest read frame.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_apb_state  <= A_IDLE;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_paddr      <= '0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
      r_cur_seq    <= 1'b0;
      r_rdata      <= '0;
      r_rd_valid   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_write <= 1'b0;
      r_pend_seq   <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
    end else begin
      case (r_apb_state)
        A_IDLE: begin
          if (w_issue_pend) begin
            r_apb_state <= A_SETUP;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_paddr     <= r_pend_addr;
            r_pwrite    <= r_pend_write;
            r_pwdata    <= r_pend_data;
            r_cur_seq   <= r_pend_seq;
          end else if (w_launch) begin
            r_apb_state <= A_SETUP;
            r_psel      <= 1'b1;
            r_penable   <= 1'b0;
            r_paddr     <= w_l_addr;
            r_pwrite    <= w_launch_wr;
            r_pwdata    <= w_l_data;
            r_cur_seq   <= ~r_rd_seq;
          end
        end
        A_SETUP: begin
          r_apb_state <= A_ACCESS;
          r_penable   <= 1'b1;
        end
        A_ACCESS: if (apb.pready) begin
          r_apb_state <= A_IDLE;
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          if (!r_pwrite && (r_cur_seq == r_rd_seq)) begin
            r_rdata    <= apb.prdata;
            r_rd_valid <= 1'b1;
          end
        end
        default: r_apb_state <= A_IDLE;
      endcase
      if (w_launch && !w_take_launch) begin
        r_pend_valid <= 1'b1;
        r_pend_addr  <= w_l_addr;
        r_pend_write <= w_launch_wr;
        r_pend_data  <= w_l_data;
        r_pend_seq   <= ~r_rd_seq;
      end else if (w_issue_pend) begin
        r_pend_valid <= 1'b0;
      end
      if (w_launch_rd) r_rd_valid <= 1'b0;
    end
  end

  // Sticky error: missed read deadline or slave error on any completed transfer.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)                            r_err <= 1'b0;
    else if (w_late || (w_done && apb.pslverr)) r_err <= 1'b1;
  end

  assign apb.paddr     = r_paddr;
  assign apb.pprot     = 3'b000;
  assign apb.psel      = r_psel;
  assign apb.penable   = r_penable;
  assign apb.pwrite    = r_pwrite;
  assign apb.pwdata    = r_pwdata;
  assign apb.pstrb     = '1;
  assign miso          = r_tx[DATA_WIDTH-1];
  assign busy          = r_psel;
  assign err           = r_err;
  assign dbg_spi_state = r_spi_state;
  assign dbg_apb_state = r_apb_state;

endmodule

// File: tb/tb_spi_apb_bridge.sv
// Directed bench for spi_apb_bridge: SPI host driver, APB slave model with
// scoreboard of expected transfers, and a summary report.
module tb_spi_apb_bridge;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int XW = 1 + AW + DW;
  localparam int THALF = 40;  // sclk half period: sclk period = 8 pclk

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, busy, err;
  logic [2:0] dbg_spi_state;
  logic [1:0] dbg_apb_state;

  spi_apb_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_if ();

  spi_apb_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .pclk(pclk), .presetn(presetn), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .busy(busy), .err(err),
    .dbg_spi_state(dbg_spi_state), .dbg_apb_state(dbg_apb_state),
    .apb(apb_if)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  int checks = 0;
  int failures = 0;
  logic [XW-1:0] exp_q[$];
  int n_setup = 0;
  int slv_stall = 0;
  logic slv_err = 1'b0;
  logic [DW-1:0] mem [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver: one mode-0 frame, MSB first, miso captured on each rising edge
  task automatic spi_frame(input int nbits, input logic [31:0] tx, output logic [31:0] rx);
    rx = '0;
    @(negedge pclk);
    cs_n = 1'b0;
    #(THALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = tx[i];
      #(THALF);
      sclk = 1'b1;
      rx = {rx[30:0], miso};
      #(THALF);
      sclk = 1'b0;
    end
    #(THALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    #100;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (apb_if.psel && n < budget) begin
      @(negedge pclk);
      n++;
    end
    check("apb_idle_timeout", apb_if.psel, 1'b0);
    repeat (3) @(negedge pclk);
  endtask

  task automatic pulse_reset();
    @(negedge pclk);
    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
  endtask

  // APB slave model + scoreboard: checks each transfer against exp_q
  initial begin : apb_slave
    logic prev_psel;
    logic was_done;
    logic [XW-1:0] cur, saved;
    int wcnt;
    prev_psel = 1'b0; wcnt = 0; saved = '0;
    apb_if.pready = 1'b0; apb_if.prdata = '0; apb_if.pslverr = 1'b0;
    forever begin
      @(negedge pclk);
      if (!presetn) begin
        prev_psel = 1'b0; wcnt = 0;
        apb_if.pready = 1'b0; apb_if.pslverr = 1'b0; apb_if.prdata = '0;
      end else begin
        was_done = apb_if.pready;
        cur = {apb_if.pwrite, apb_if.paddr, apb_if.pwrite ? apb_if.pwdata : {DW{1'b0}}};
        if (was_done) check("psel_drop_after_pready", {apb_if.psel, apb_if.penable}, 2'b00);
        if (apb_if.psel && !apb_if.penable) begin
          n_setup++;
          check("setup_after_idle", prev_psel, 1'b0);
          check("pstrb_pprot", {apb_if.pstrb, apb_if.pprot}, 4'b1000);
          check("busy_during_setup", busy, 1'b1);
          check("unexpected_xfer", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) check("xfer_fields", cur, exp_q.pop_front());
          saved = cur;
        end else if (apb_if.psel && apb_if.penable && !was_done) begin
          check("req_stable", cur, saved);
        end
        if (was_done) begin
          apb_if.pready = 1'b0; apb_if.pslverr = 1'b0; wcnt = 0;
        end else if (apb_if.psel && apb_if.penable) begin
          if (wcnt >= slv_stall) begin
            apb_if.pready  = 1'b1;
            apb_if.pslverr = slv_err;
            if (apb_if.pwrite) begin
              if (!slv_err) mem[apb_if.paddr] = apb_if.pwdata;
            end else begin
              apb_if.prdata = mem[apb_if.paddr];
            end
          end else begin
            wcnt++;
          end
        end
        prev_psel = apb_if.psel;
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] rx;
    int n_before;
    int n;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    // reset state
    repeat (4) @(negedge pclk);
    check("rst_apb", {apb_if.psel, apb_if.penable, apb_if.pwrite}, 3'b000);
    check("rst_paddr_pwdata", {apb_if.paddr, apb_if.pwdata}, '0);
    check("rst_miso_busy_err", {miso, busy, err}, 3'b000);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);

    // write 0x83,0xA5
    exp_q.push_back({1'b1, 3'd3, 8'hA5});
    spi_frame(16, 32'h83A5, rx);
    wait_idle(100);
    check("wr_count", n_setup, 1);
    check("wr_err_clear", err, 1'b0);

    // read back address 3
    exp_q.push_back({1'b0, 3'd3, 8'h00});
    spi_frame(24, 32'h030000, rx);
    wait_idle(100);
    check("rd_miso", rx[23:0], 24'h0000A5);
    check("rd_miso_idle", miso, 1'b0);

    // aborted write: 12 bits then cs_n high
    n_before = n_setup;
    spi_frame(12, 32'h85A, rx);
    repeat (40) @(negedge pclk);
    check("abort_no_xfer", n_setup, n_before);
    exp_q.push_back({1'b1, 3'd5, 8'h3C});
    spi_frame(16, 32'h853C, rx);
    wait_idle(100);
    exp_q.push_back({1'b0, 3'd5, 8'h00});
    spi_frame(24, 32'h050000, rx);
    wait_idle(100);
    check("after_abort_rd", rx[23:0], 24'h00003C);
    check("after_abort_err", err, 1'b0);

    // late read: slave stalls past the data byte deadline
    slv_stall = 120;
    exp_q.push_back({1'b0, 3'd3, 8'h00});
    spi_frame(24, 32'h030000, rx);
    wait_idle(400);
    slv_stall = 0;
    check("late_rd_miso", rx[23:0], 24'h000000);
    check("late_rd_err", err, 1'b1);

    pulse_reset();
    check("reset_clears_err", err, 1'b0);

    // slave error on write to address 1, then err stays set
    slv_err = 1'b1;
    exp_q.push_back({1'b1, 3'd1, 8'h55});
    spi_frame(16, 32'h8155, rx);
    wait_idle(100);
    slv_err = 1'b0;
    check("slverr_err", err, 1'b1);
    exp_q.push_back({1'b0, 3'd3, 8'h00});
    spi_frame(24, 32'h030000, rx);
    wait_idle(100);
    check("slverr_next_rd", rx[23:0], 24'h0000A5);
    check("slverr_sticky", err, 1'b1);

    // reset while the slave holds the write in ACCESS
    slv_stall = 200;
    exp_q.push_back({1'b1, 3'd2, 8'h11});
    spi_frame(16, 32'h8211, rx);
    n = 0;
    while (!(apb_if.psel && apb_if.penable) && n < 100) begin
      @(negedge pclk);
      n++;
    end
    check("reached_access", apb_if.psel && apb_if.penable, 1'b1);
    #2;
    presetn = 1'b0;
    #1;
    check("rst_mid_access", {apb_if.psel, apb_if.penable, miso, err}, 4'b0000);
    repeat (3) @(negedge pclk);
    slv_stall = 0;
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
    exp_q.push_back({1'b1, 3'd6, 8'h77});
    spi_frame(16, 32'h8677, rx);
    wait_idle(100);
    exp_q.push_back({1'b0, 3'd2, 8'h00});
    spi_frame(24, 32'h020000, rx);
    wait_idle(100);
    check("aborted_wr_not_done", rx[23:0], 24'h000000);
    exp_q.push_back({1'b0, 3'd6, 8'h00});
    spi_frame(24, 32'h060000, rx);
    wait_idle(100);
    check("post_reset_rd", rx[23:0], 24'h000077);
    check("post_reset_err", err, 1'b0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
